// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, decode classes,
// opcode/funct fields and the select/opcode codes driven onto the datapath.
package mips_ctrl_pkg;

  // FSM states; the numeric values are visible on state_o
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExeR   = 4'd2,
    StExeI   = 4'd3,
    StExeMem = 4'd4,
    StMemRd  = 4'd5,
    StMemWb  = 4'd6,
    StMemWr  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAluWb  = 4'd10,
    StTrap   = 4'd11
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    ClsR      = 3'd0,
    ClsI      = 3'd1,
    ClsMem    = 3'd2,
    ClsBranch = 3'd3,
    ClsJump   = 3'd4,
    ClsIll    = 3'd5
  } cls_e;

  // Opcode field values
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJal   = 6'b000011;

  // Funct field values (op == OpRtype)
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnJr   = 6'b001000;

  // ALU operation codes (zero-extended to ALUOP_W at the port)
  localparam logic [3:0] AluAnd = 4'b0001;
  localparam logic [3:0] AluOr  = 4'b0010;
  localparam logic [3:0] AluAdd = 4'b0101;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b1010;

  // Next-PC source
  localparam logic [1:0] NpcPc4    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;
  localparam logic [1:0] NpcRs     = 2'b11;

  // Immediate extension
  localparam logic [1:0] ExtZero = 2'b00;
  localparam logic [1:0] ExtSign = 2'b01;
  localparam logic [1:0] ExtHi   = 2'b10;

  // Register-file write data source
  localparam logic [1:0] DselPc  = 2'b00;
  localparam logic [1:0] DselDr  = 2'b01;
  localparam logic [1:0] DselAlu = 2'b10;

  // Register-file write address source
  localparam logic [1:0] RselRd = 2'b00;
  localparam logic [1:0] RselRt = 2'b01;
  localparam logic [1:0] RselRa = 2'b10;

  // Trap causes
  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier. Extended instructions (addi, slt, lui,
// bne, jr) fall into the illegal class when SUPPORT_EXT is 0.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_EXT = 1'b1
) (
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_e       o_cls,
  output logic       o_illegal
);

  // Map opcode/funct onto an instruction class
  always_comb begin
    o_cls = ClsIll;
    case (i_op)
      OpRtype: begin
        case (i_funct)
          FnAddu, FnSubu: o_cls = ClsR;
          FnSlt:          o_cls = SUPPORT_EXT ? ClsR : ClsIll;
          FnJr:           o_cls = SUPPORT_EXT ? ClsJump : ClsIll;
          default:        o_cls = ClsIll;
        endcase
      end
      OpOri:         o_cls = ClsI;
      OpAddi, OpLui: o_cls = SUPPORT_EXT ? ClsI : ClsIll;
      OpLw, OpSw:    o_cls = ClsMem;
      OpBeq:         o_cls = ClsBranch;
      OpBne:         o_cls = SUPPORT_EXT ? ClsBranch : ClsIll;
      OpJal:         o_cls = ClsJump;
      default:       o_cls = ClsIll;
    endcase
  end

  assign o_illegal = (o_cls == ClsIll);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on mem_ready with an optional timeout, and halts in a sticky trap state.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,  // must be at least 4
  parameter bit          SUPPORT_EXT = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15  // 0 disables the timeout
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               rf_wr,
  output logic               dm_wr,
  output logic               dm_rd,
  output logic               im_rd,
  output logic               b_sel,
  output logic [1:0]         d_sel,
  output logic [1:0]         r_sel,
  output logic [1:0]         npcop,
  output logic [1:0]         extop,
  output logic [ALUOP_W-1:0] aluop,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o
);

  // Wait count never exceeds MEM_TIMEOUT-1
  localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_wait, w_wait_nxt;
  logic [1:0]      r_cause, w_cause_nxt;
  cls_e            w_cls;
  logic            w_illegal;
  logic            w_timeout;
  logic            w_wait_state;

  ctrl_decode #(
    .SUPPORT_EXT(SUPPORT_EXT)
  ) u_decode (
    .i_op     (op),
    .i_funct  (funct),
    .o_cls    (w_cls),
    .o_illegal(w_illegal)
  );

  assign w_wait_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  // Last allowed not-ready cycle; a ready in this same cycle still wins
  assign w_timeout    = (MEM_TIMEOUT != 0) && !mem_ready &&
                        (r_wait == CntW'(MEM_TIMEOUT - 1));

  // Next state, trap cause and datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    pc_wr       = 1'b0;
    ir_wr       = 1'b0;
    rf_wr       = 1'b0;
    dm_wr       = 1'b0;
    dm_rd       = 1'b0;
    im_rd       = 1'b0;
    b_sel       = 1'b0;
    d_sel       = DselPc;
    r_sel       = RselRd;
    npcop       = NpcPc4;
    extop       = ExtZero;
    aluop       = ALUOP_W'(AluAdd);
    case (r_state)
      StFetch: begin
        im_rd = 1'b1;
        if (mem_ready) begin
          pc_wr       = 1'b1;
          ir_wr       = 1'b1;
          w_state_nxt = StDecode;
        end else if (w_timeout) begin
          w_state_nxt = StTrap;
          w_cause_nxt = CauseTimeout;
        end
      end
      StDecode: begin
        if (w_illegal) begin
          w_state_nxt = StTrap;
          w_cause_nxt = CauseIllegal;
        end else begin
          case (w_cls)
            ClsR:      w_state_nxt = StExeR;
            ClsI:      w_state_nxt = StExeI;
            ClsMem:    w_state_nxt = StExeMem;
            ClsBranch: w_state_nxt = StBranch;
            ClsJump:   w_state_nxt = StJump;
            default: begin
              w_state_nxt = StTrap;
              w_cause_nxt = CauseIllegal;
            end
          endcase
        end
      end
      StExeR: begin
        case (funct)
          FnSubu:  aluop = ALUOP_W'(AluSub);
          FnSlt:   aluop = ALUOP_W'(AluSlt);
          default: aluop = ALUOP_W'(AluAdd);
        endcase
        w_state_nxt = StAluWb;
      end
      StExeI: begin
        b_sel = 1'b1;
        case (op)
          OpAddi: begin
            extop = ExtSign;
            aluop = ALUOP_W'(AluAdd);
          end
          // lui relies on rs being $0 so OR passes the shifted immediate
          OpLui: begin
            extop = ExtHi;
            aluop = ALUOP_W'(AluOr);
          end
          default: begin
            extop = ExtZero;
            aluop = ALUOP_W'(AluOr);
          end
        endcase
        w_state_nxt = StAluWb;
      end
      StAluWb: begin
        rf_wr       = 1'b1;
        d_sel       = DselAlu;
        r_sel       = (op == OpRtype) ? RselRd : RselRt;
        w_state_nxt = StFetch;
      end
      StExeMem: begin
        b_sel       = 1'b1;
        extop       = ExtSign;
        aluop       = ALUOP_W'(AluAdd);
        w_state_nxt = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        dm_rd = 1'b1;
        if (mem_ready) begin
          w_state_nxt = StMemWb;
        end else if (w_timeout) begin
          w_state_nxt = StTrap;
          w_cause_nxt = CauseTimeout;
        end
      end
      StMemWb: begin
        rf_wr       = 1'b1;
        d_sel       = DselDr;
        r_sel       = RselRt;
        w_state_nxt = StFetch;
      end
      StMemWr: begin
        dm_wr = 1'b1;
        if (mem_ready) begin
          w_state_nxt = StFetch;
        end else if (w_timeout) begin
          w_state_nxt = StTrap;
          w_cause_nxt = CauseTimeout;
        end
      end
      StBranch: begin
        aluop       = ALUOP_W'(AluSub);
        npcop       = NpcBranch;
        pc_wr       = (op == OpBne) ? !zero : zero;
        w_state_nxt = StFetch;
      end
      StJump: begin
        pc_wr = 1'b1;
        if (op == OpJal) begin
          npcop = NpcJump;
          rf_wr = 1'b1;
          d_sel = DselPc;
          r_sel = RselRa;
        end else begin
          npcop = NpcRs;
        end
        w_state_nxt = StFetch;
      end
      StTrap: w_state_nxt = StTrap;
      default: w_state_nxt = StFetch;
    endcase
    // Reset must silence every strobe, even though the state already reads FETCH
    if (!rst) begin
      pc_wr = 1'b0;
      ir_wr = 1'b0;
      rf_wr = 1'b0;
      dm_wr = 1'b0;
      dm_rd = 1'b0;
      im_rd = 1'b0;
    end
  end

  // Wait counter: counts not-ready cycles in memory-wait states, clears on any state change
  always_comb begin
    w_wait_nxt = r_wait;
    if (w_state_nxt != r_state) begin
      w_wait_nxt = '0;
    end else if (w_wait_state && !mem_ready) begin
      w_wait_nxt = r_wait + CntW'(1);
    end
  end

  // State, wait counter and trap cause registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StFetch;
      r_wait  <= '0;
      r_cause <= CauseNone;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  assign trap       = (r_state == StTrap);
  assign trap_cause = r_cause;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a default instance plus an 8-bit-aluop,
// no-extension instance sharing the same stimulus.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_wr, ir_wr, rf_wr, dm_wr, dm_rd, im_rd, b_sel, trap;
  logic [1:0] d_sel, r_sel, npcop, extop, trap_cause;
  logic [3:0] aluop, state_o;
  logic [5:0] strb;

  logic       d2_pc_wr, d2_ir_wr, d2_rf_wr, d2_dm_wr, d2_dm_rd, d2_im_rd, d2_b_sel, d2_trap;
  logic [1:0] d2_d_sel, d2_r_sel, d2_npcop, d2_extop, d2_cause;
  logic [7:0] d2_aluop;
  logic [3:0] d2_state;
  logic [5:0] d2_strb;

  int checks = 0;
  int errors = 0;

  assign strb    = {pc_wr, ir_wr, rf_wr, dm_wr, dm_rd, im_rd};
  assign d2_strb = {d2_pc_wr, d2_ir_wr, d2_rf_wr, d2_dm_wr, d2_dm_rd, d2_im_rd};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .im_rd(im_rd), .b_sel(b_sel), .d_sel(d_sel), .r_sel(r_sel), .npcop(npcop),
    .extop(extop), .aluop(aluop), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  multicycle_ctrl #(
    .ALUOP_W(8), .SUPPORT_EXT(1'b0), .MEM_TIMEOUT(15)
  ) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(d2_pc_wr), .ir_wr(d2_ir_wr), .rf_wr(d2_rf_wr), .dm_wr(d2_dm_wr),
    .dm_rd(d2_dm_rd), .im_rd(d2_im_rd), .b_sel(d2_b_sel), .d_sel(d2_d_sel),
    .r_sel(d2_r_sel), .npcop(d2_npcop), .extop(d2_extop), .aluop(d2_aluop),
    .trap(d2_trap), .trap_cause(d2_cause), .state_o(d2_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    // Reset: FETCH, no strobes although mem_ready is high
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    chk("d2_rst_aluop", 32'(d2_aluop), 32'h05);
    @(posedge clk); #1;

    // addu
    rst = 1'b1; op = 6'b000000; funct = 6'b100001; mem_ready = 1'b1; #1;
    chk("addu_fetch_state", 32'(state_o), 32'd0);
    chk("addu_fetch_strb", 32'(strb), 32'b110001);
    chk("addu_fetch_npc", 32'(npcop), 32'd0);
    nxt(); chk("addu_dec_state", 32'(state_o), 32'd1);
    chk("addu_dec_strb", 32'(strb), 32'd0);
    nxt(); chk("addu_exer_state", 32'(state_o), 32'd2);
    chk("addu_exer_bsel", 32'(b_sel), 32'd0);
    chk("addu_exer_alu", 32'(aluop), 32'b0101);
    nxt(); chk("addu_wb_state", 32'(state_o), 32'd10);
    chk("addu_wb_strb", 32'(strb), 32'b001000);
    chk("addu_wb_dsel", 32'(d_sel), 32'd2);
    chk("addu_wb_rsel", 32'(r_sel), 32'd0);
    chk("addu_wb_alu", 32'(aluop), 32'b0101);
    nxt(); chk("addu_back_fetch", 32'(state_o), 32'd0);

    // lw with three not-ready cycles in MEM_RD
    op = 6'b100011;
    nxt(); chk("lw_dec_state", 32'(state_o), 32'd1);
    nxt(); chk("lw_exemem_state", 32'(state_o), 32'd4);
    chk("lw_exemem_bsel", 32'(b_sel), 32'd1);
    chk("lw_exemem_ext", 32'(extop), 32'd1);
    chk("lw_exemem_alu", 32'(aluop), 32'b0101);
    mem_ready = 1'b0;
    nxt(); chk("lw_rd1_strb", 32'(strb), 32'b000010);
    nxt(); chk("lw_rd2_strb", 32'(strb), 32'b000010);
    nxt(); chk("lw_rd3_state", 32'(state_o), 32'd5);
    nxt(); mem_ready = 1'b1; #1;
    chk("lw_rd4_state", 32'(state_o), 32'd5);
    chk("lw_rd4_strb", 32'(strb), 32'b000010);
    nxt(); chk("lw_wb_state", 32'(state_o), 32'd6);
    chk("lw_wb_strb", 32'(strb), 32'b001000);
    chk("lw_wb_dsel", 32'(d_sel), 32'd1);
    chk("lw_wb_rsel", 32'(r_sel), 32'd1);
    nxt(); chk("lw_back_fetch", 32'(state_o), 32'd0);

    // bne, taken and not taken
    op = 6'b000101; zero = 1'b1;
    nxt(); nxt();
    chk("bne_z1_state", 32'(state_o), 32'd8);
    chk("bne_z1_strb", 32'(strb), 32'd0);
    chk("bne_z1_alu", 32'(aluop), 32'b0110);
    nxt(); chk("bne_z1_fetch", 32'(state_o), 32'd0);
    zero = 1'b0;
    nxt(); nxt();
    chk("bne_z0_strb", 32'(strb), 32'b100000);
    chk("bne_z0_npc", 32'(npcop), 32'd1);
    nxt(); chk("bne_z0_fetch", 32'(state_o), 32'd0);

    // jal
    op = 6'b000011;
    nxt(); nxt();
    chk("jal_state", 32'(state_o), 32'd9);
    chk("jal_strb", 32'(strb), 32'b101000);
    chk("jal_npc", 32'(npcop), 32'd2);
    chk("jal_dsel", 32'(d_sel), 32'd0);
    chk("jal_rsel", 32'(r_sel), 32'd2);
    nxt();
    // jr
    op = 6'b000000; funct = 6'b001000;
    nxt(); nxt();
    chk("jr_strb", 32'(strb), 32'b100000);
    chk("jr_npc", 32'(npcop), 32'd3);
    nxt();
    // lui
    op = 6'b001111;
    nxt(); nxt();
    chk("lui_state", 32'(state_o), 32'd3);
    chk("lui_bsel", 32'(b_sel), 32'd1);
    chk("lui_ext", 32'(extop), 32'd2);
    chk("lui_alu", 32'(aluop), 32'b0010);
    nxt(); chk("lui_wb_rsel", 32'(r_sel), 32'd1);
    nxt();
    // sw completing in its first MEM_WR cycle
    op = 6'b101011;
    nxt(); nxt(); nxt();
    chk("sw_state", 32'(state_o), 32'd7);
    chk("sw_strb", 32'(strb), 32'b000100);
    nxt(); chk("sw_fetch", 32'(state_o), 32'd0);

    // Fetch timeout near miss: ready arrives on the 15th cycle
    op = 6'b000000; funct = 6'b100001; mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) nxt();
    chk("tmo_miss_state", 32'(state_o), 32'd0);
    mem_ready = 1'b1; #1;
    chk("tmo_miss_strb", 32'(strb), 32'b110001);
    nxt(); chk("tmo_miss_decode", 32'(state_o), 32'd1);
    nxt(); nxt(); nxt();
    chk("tmo_miss_fetch", 32'(state_o), 32'd0);

    // Reset in MEM_WR abandons the store at once
    op = 6'b101011;
    nxt(); nxt(); mem_ready = 1'b0;
    nxt(); chk("swrst_strb", 32'(strb), 32'b000100);
    rst = 1'b0; #1;
    chk("swrst_drop_strb", 32'(strb), 32'd0);
    chk("swrst_state", 32'(state_o), 32'd0);
    nxt(); rst = 1'b1; #1;
    chk("swrst_rel_strb", 32'(strb), 32'b000001);
    chk("swrst_rel_trap", 32'(trap), 32'd0);

    // Fetch timeout: 15 not-ready cycles
    for (int i = 0; i < 14; i++) nxt();
    chk("tmo_pre_state", 32'(state_o), 32'd0);
    nxt();
    chk("tmo_state", 32'(state_o), 32'd11);
    chk("tmo_trap", 32'(trap), 32'd1);
    chk("tmo_cause", 32'(trap_cause), 32'd2);
    chk("tmo_strb", 32'(strb), 32'd0);

    // Reset clears trap
    rst = 1'b0; #1;
    chk("trst_trap", 32'(trap), 32'd0);
    chk("trst_cause", 32'(trap_cause), 32'd0);
    nxt();

    // Illegal opcode traps and stays silent
    op = 6'b111111; mem_ready = 1'b1; rst = 1'b1; #1;
    nxt(); chk("ill_dec_state", 32'(state_o), 32'd1);
    nxt();
    chk("ill_state", 32'(state_o), 32'd11);
    chk("ill_cause", 32'(trap_cause), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = ~mem_ready;
      nxt();
      chk("ill_hold_strb", 32'(strb), 32'd0);
    end
    chk("ill_hold_trap", 32'(trap), 32'd1);
    chk("ill_hold_cause", 32'(trap_cause), 32'd1);

    // slt: legal on the default instance, illegal without extensions
    rst = 1'b0; #1;
    nxt();
    op = 6'b000000; funct = 6'b101010; mem_ready = 1'b1; rst = 1'b1; #1;
    nxt(); nxt();
    chk("slt_state", 32'(state_o), 32'd2);
    chk("slt_alu", 32'(aluop), 32'b1010);
    chk("d2_slt_state", 32'(d2_state), 32'd11);
    chk("d2_slt_trap", 32'(d2_trap), 32'd1);
    chk("d2_slt_cause", 32'(d2_cause), 32'd1);
    chk("d2_slt_strb", 32'(d2_strb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
